// File: rtl/alu_decode_pipe.sv
// alu_decode_pipe
// ---------------
// RV32/RV64 integer instruction decoder followed by a 2-entry output FIFO.
// Each incoming instruction word is decoded combinationally into an ALU
// operation, an instruction format, a sign-extended immediate and the
// load/store/branch qualifiers. The decoded record is then written into a
// two-slot FIFO so the consumer side can stall without dropping entries.
// Undecodable words are passed through flagged as illegal and counted.
//
// Parameters
//   XLEN     : PC / immediate width, 32 or 64
//   EN_MEXT  : nonzero enables decode of the M extension (MUL..REMU)
//   CNT_W    : width of the saturating illegal-instruction counter
//
// Ports
//   clk                         : clock, all state updates on rising edge
//   rst                         : asynchronous reset, active low
//   in_valid / in_ready         : input handshake (in_ready is registered)
//   in_instr [31:0], in_pc      : instruction word and its address
//   flush                       : empty the FIFO at the next edge
//   out_valid / out_ready       : output handshake for the head entry
//   out_alu_op [4:0]            : ALU operation code
//   out_fmt [2:0]               : R=0 I=1 S=2 B=3 U=4 J=5 LOAD=6 NONE=7
//   out_imm                     : sign-extended immediate
//   out_br_type [2:0]           : branch funct3 (B format only)
//   out_mem_size [1:0]          : access size for loads/stores
//   out_mem_unsigned            : zero-extending load
//   out_rd/out_rs1/out_rs2      : register indices
//   out_pc                      : PC of the head entry
//   out_illegal                 : head entry is an undecodable instruction
//   illegal_cnt                 : saturating count of accepted illegal words
module alu_decode_pipe #(
    parameter int XLEN    = 32,
    parameter int EN_MEXT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_alu_op,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_br_type,
    output logic [1:0]       out_mem_size,
    output logic             out_mem_unsigned,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_LOAD = 3'd6;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [4:0]      alu_op;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic [2:0]      br_type;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    // Shared funct3 -> ALU mapping of the OP and OP-IMM groups.
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic            slli_ok, srxi_ok;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // Shift amount width and the funct bits above it depend on XLEN;
    // bit 30 is the SRAI selector and is the only upper bit allowed set.
    if (XLEN == 64) begin : g_x64
        assign imm_u   = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
        assign imm_sh  = {58'd0, in_instr[25:20]};
        assign slli_ok = (in_instr[31:26] == 6'd0);
        assign srxi_ok = ({in_instr[31], in_instr[29:26]} == 5'd0);
    end else begin : g_x32
        assign imm_u   = {in_instr[31:12], 12'd0};
        assign imm_sh  = {27'd0, in_instr[24:20]};
        assign slli_ok = (in_instr[31:25] == 7'd0);
        assign srxi_ok = ({in_instr[31], in_instr[29:25]} == 6'd0);
    end

    logic [4:0]      dec_alu;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_br;
    logic [1:0]      dec_msz;
    logic            dec_muns;
    logic            dec_bad;
    entry_t          dec_entry;

    always_comb begin
        dec_alu  = ALU_ADD;
        dec_fmt  = FMT_NONE;
        dec_imm  = '0;
        dec_br   = 3'd0;
        dec_msz  = 2'd0;
        dec_muns = 1'b0;
        dec_bad  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_fmt = FMT_R;
                if (f7 == 7'b0000000) begin
                    dec_alu = base_alu(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
                    dec_alu = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
                    dec_alu = ALU_SRA;
                end else if (f7 == 7'b0000001 && EN_MEXT != 0) begin
                    dec_alu = {2'b10, f3};      // MUL..REMU = 16 + funct3
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec_fmt = FMT_I;
                if (f3 == 3'd1) begin
                    dec_alu = ALU_SLL;
                    dec_imm = imm_sh;
                    dec_bad = !slli_ok;
                end else if (f3 == 3'd5) begin
                    dec_alu = in_instr[30] ? ALU_SRA : ALU_SRL;
                    dec_imm = imm_sh;
                    dec_bad = !srxi_ok;
                end else begin
                    dec_alu = base_alu(f3);
                    dec_imm = imm_i;
                end
            end
            OPC_LOAD: begin
                dec_fmt  = FMT_LOAD;
                dec_imm  = imm_i;
                dec_msz  = f3[1:0];
                dec_muns = f3[2];
                // LD and LWU exist only on RV64.
                dec_bad  = (f3 == 3'd7) ||
                           (XLEN == 32 && (f3 == 3'd3 || f3 == 3'd6));
            end
            OPC_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = imm_s;
                dec_msz = f3[1:0];
                dec_bad = f3[2] || (XLEN == 32 && f3 == 3'd3);
            end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = imm_b;
                dec_br  = f3;
                // BLTU/BGEU compare unsigned; the signed/equality forms use SUB.
                dec_alu = (f3[2] && f3[1]) ? ALU_SLTU : ALU_SUB;
                dec_bad = (f3[2:1] == 2'b01);
            end
            OPC_LUI: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
                dec_alu = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
            end
            OPC_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = imm_j;
            end
            OPC_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
                dec_bad = (f3 != 3'd0);
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        dec_entry.alu_op       = dec_bad ? ALU_ADD  : dec_alu;
        dec_entry.fmt          = dec_bad ? FMT_NONE : dec_fmt;
        dec_entry.imm          = dec_bad ? '0       : dec_imm;
        dec_entry.br_type      = dec_bad ? 3'd0     : dec_br;
        dec_entry.mem_size     = dec_bad ? 2'd0     : dec_msz;
        dec_entry.mem_unsigned = dec_bad ? 1'b0     : dec_muns;
        dec_entry.rd           = in_instr[11:7];
        dec_entry.rs1          = in_instr[19:15];
        dec_entry.rs2          = in_instr[24:20];
        dec_entry.pc           = in_pc;
        dec_entry.illegal      = dec_bad;
    end

    // ------------------------------------------------------------------
    // Two-entry FIFO
    // ------------------------------------------------------------------
    logic [1:0]       occ_reg, occ_next;
    logic             wr_ptr_reg, wr_ptr_next;
    logic             rd_ptr_reg, rd_ptr_next;
    logic             in_ready_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept, release_w;
    entry_t           slot_mem [0:1];
    entry_t           head;

    assign out_valid = (occ_reg != 2'd0);
    assign in_ready  = in_ready_reg;
    // flush wins over a same-cycle offer.
    assign accept    = in_valid && in_ready_reg && !flush;
    assign release_w = out_valid && out_ready;

    always_comb begin
        occ_next    = occ_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        if (flush) begin
            occ_next    = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            if (accept) wr_ptr_next = ~wr_ptr_reg;
            if (release_w) rd_ptr_next = ~rd_ptr_reg;
            case ({accept, release_w})
                2'b10:   occ_next = occ_reg + 2'd1;
                2'b01:   occ_next = occ_reg - 2'd1;
                default: occ_next = occ_reg;
            endcase
            if (accept && dec_bad && (cnt_reg != {CNT_W{1'b1}}))
                cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_reg      <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            occ_reg      <= occ_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            in_ready_reg <= (occ_next < 2'd2);
            cnt_reg      <= cnt_next;
        end
    end

    // Payload storage needs no reset: it is only visible through out_valid.
    always_ff @(posedge clk) begin
        if (accept) slot_mem[wr_ptr_reg] <= dec_entry;
    end

    // Data outputs read as zero whenever nothing is buffered, which also
    // gives all-zero outputs during and right after reset.
    assign head = out_valid ? slot_mem[rd_ptr_reg] : '0;

    assign out_alu_op       = head.alu_op;
    assign out_fmt          = head.fmt;
    assign out_imm          = head.imm;
    assign out_br_type      = head.br_type;
    assign out_mem_size     = head.mem_size;
    assign out_mem_unsigned = head.mem_unsigned;
    assign out_rd           = head.rd;
    assign out_rs1          = head.rs1;
    assign out_rs2          = head.rs2;
    assign out_pc           = head.pc;
    assign out_illegal      = head.illegal;
    assign illegal_cnt      = cnt_reg;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Testbench for alu_decode_pipe: two instances (RV32 without M, RV64 with M
// and a 3-bit counter) share one stimulus stream and are checked each cycle
// against an instruction-level reference model plus directed literal cases.
module tb_alu_decode_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_muns, a_ill;
    logic [4:0]  a_alu, a_rd, a_rs1, a_rs2;
    logic [2:0]  a_fmt, a_br;
    logic [1:0]  a_msz;
    logic [31:0] a_imm, a_pc;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_muns, b_ill;
    logic [4:0]  b_alu, b_rd, b_rs1, b_rs2;
    logic [2:0]  b_fmt, b_br;
    logic [1:0]  b_msz;
    logic [63:0] b_imm, b_pc;
    logic [2:0]  b_cnt;

    alu_decode_pipe #(.XLEN(32), .EN_MEXT(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_alu_op(a_alu),
        .out_fmt(a_fmt), .out_imm(a_imm), .out_br_type(a_br),
        .out_mem_size(a_msz), .out_mem_unsigned(a_muns), .out_rd(a_rd),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_pc(a_pc),
        .out_illegal(a_ill), .illegal_cnt(a_cnt));

    alu_decode_pipe #(.XLEN(64), .EN_MEXT(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_alu_op(b_alu),
        .out_fmt(b_fmt), .out_imm(b_imm), .out_br_type(b_br),
        .out_mem_size(b_msz), .out_mem_unsigned(b_muns), .out_rd(b_rd),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_pc(b_pc),
        .out_illegal(b_ill), .illegal_cnt(b_cnt));

    typedef struct {
        int          alu;
        int          fmt;
        logic [63:0] imm;
        int          br;
        int          msz;
        int          muns;
        int          ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   cnt_a, cnt_b;
    int   checks = 0;
    int   errors = 0;
    bit   run_checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Unsigned field of n bits starting at bit lo, as a signed 64-bit number.
    function automatic longint fld(input logic [31:0] w, input int lo, input int n);
        longint f;
        f = (w >> lo) & ((32'd1 << n) - 32'd1);
        return f;
    endfunction

    // Reference decode: what each RISC-V instruction means, from the ISA.
    function automatic exp_t model_dec(input logic [31:0] w, input bit rv64, input bit mext);
        int     base_alu[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int     op, f3, f7, shw;
        longint sgn, i_imm;
        exp_t   e;
        op    = int'(fld(w, 0, 7));
        f3    = int'(fld(w, 12, 3));
        f7    = int'(fld(w, 25, 7));
        sgn   = w[31] ? -64'sd1 : 64'sd0;
        shw   = rv64 ? 26 : 25;
        i_imm = sgn * 2048 + fld(w, 20, 11);
        e.alu = 0; e.fmt = 7; e.imm = 0; e.br = 0; e.msz = 0; e.muns = 0; e.ill = 1;
        case (op)
            'h33: begin
                e.fmt = 0;
                if (f7 == 0) begin e.alu = base_alu[f3]; e.ill = 0; end
                else if (f7 == 'h20 && f3 == 0) begin e.alu = 1; e.ill = 0; end
                else if (f7 == 'h20 && f3 == 5) begin e.alu = 7; e.ill = 0; end
                else if (f7 == 1 && mext) begin e.alu = 16 + f3; e.ill = 0; end
            end
            'h13: begin
                e.fmt = 1;
                if (f3 == 1) begin
                    e.alu = 2;
                    e.imm = fld(w, 20, rv64 ? 6 : 5);
                    e.ill = (fld(w, shw, 32 - shw) != 0);
                end else if (f3 == 5) begin
                    e.alu = w[30] ? 7 : 6;
                    e.imm = fld(w, 20, rv64 ? 6 : 5);
                    e.ill = ((fld(w, shw, 32 - shw) & ~(64'sd1 << (30 - shw))) != 0);
                end else begin
                    e.alu = base_alu[f3];
                    e.imm = i_imm;
                    e.ill = 0;
                end
            end
            'h03: begin
                e.fmt = 6; e.imm = i_imm; e.msz = f3 % 4; e.muns = (f3 >= 4);
                e.ill = !((f3 inside {0, 1, 2, 4, 5}) || (rv64 && (f3 == 3 || f3 == 6)));
            end
            'h23: begin
                e.fmt = 2; e.msz = f3 % 4;
                e.imm = sgn * 2048 + fld(w, 25, 6) * 32 + fld(w, 7, 5);
                e.ill = !(f3 < 3 || (rv64 && f3 == 3));
            end
            'h63: begin
                e.fmt = 3; e.br = f3; e.alu = (f3 >= 6) ? 4 : 1;
                e.imm = sgn * 4096 + fld(w, 7, 1) * 2048 + fld(w, 25, 6) * 32 + fld(w, 8, 4) * 2;
                e.ill = (f3 == 2 || f3 == 3);
            end
            'h37: begin
                e.fmt = 4; e.alu = 10; e.ill = 0;
                e.imm = sgn * 2048 * 1048576 + fld(w, 12, 19) * 4096;
            end
            'h17: begin
                e.fmt = 4; e.alu = 0; e.ill = 0;
                e.imm = sgn * 2048 * 1048576 + fld(w, 12, 19) * 4096;
            end
            'h6F: begin
                e.fmt = 5; e.ill = 0;
                e.imm = sgn * 1048576 + fld(w, 12, 8) * 4096 + fld(w, 20, 1) * 2048 + fld(w, 21, 10) * 2;
            end
            'h67: begin
                e.fmt = 1; e.imm = i_imm; e.ill = (f3 != 0);
            end
            default: e.ill = 1;
        endcase
        if (e.ill != 0) begin
            e.alu = 0; e.fmt = 7; e.imm = 0; e.br = 0; e.msz = 0; e.muns = 0;
        end
        return e;
    endfunction

    // Queue-level model of the buffer: occupancy is simply the queue length.
    task automatic model_step();
        bit   acc, rel;
        exp_t xa, xb;
        if (!rst) begin
            q.delete();
            m_ready = 0; cnt_a = 0; cnt_b = 0;
        end else begin
            acc = in_valid && m_ready && !flush;
            rel = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (rel) void'(q.pop_front());
                if (acc) q.push_back('{instr: in_instr, pc: in_pc});
            end
            if (acc) begin
                xa = model_dec(in_instr, 0, 0);
                xb = model_dec(in_instr, 1, 1);
                if (xa.ill != 0 && cnt_a < 65535) cnt_a++;
                if (xb.ill != 0 && cnt_b < 7) cnt_b++;
            end
            m_ready = (q.size() < 2);
        end
    endtask

    always @(posedge clk or negedge rst) model_step();

    task automatic check_all();
        exp_t ea, eb;
        chk("a_in_ready", a_in_ready, m_ready);
        chk("b_in_ready", b_in_ready, m_ready);
        chk("a_out_valid", a_out_valid, q.size() > 0);
        chk("b_out_valid", b_out_valid, q.size() > 0);
        chk("a_illegal_cnt", a_cnt, cnt_a);
        chk("b_illegal_cnt", b_cnt, cnt_b);
        if (q.size() > 0) begin
            ea = model_dec(q[0].instr, 0, 0);
            eb = model_dec(q[0].instr, 1, 1);
            chk("a_alu", a_alu, ea.alu);         chk("b_alu", b_alu, eb.alu);
            chk("a_fmt", a_fmt, ea.fmt);         chk("b_fmt", b_fmt, eb.fmt);
            chk("a_imm", a_imm, ea.imm[31:0]);   chk("b_imm", b_imm, eb.imm);
            chk("a_br", a_br, ea.br);            chk("b_br", b_br, eb.br);
            chk("a_msz", a_msz, ea.msz);         chk("b_msz", b_msz, eb.msz);
            chk("a_muns", a_muns, ea.muns);      chk("b_muns", b_muns, eb.muns);
            chk("a_ill", a_ill, ea.ill);         chk("b_ill", b_ill, eb.ill);
            chk("a_rd", a_rd, q[0].instr[11:7]); chk("b_rd", b_rd, q[0].instr[11:7]);
            chk("a_rs1", a_rs1, q[0].instr[19:15]);
            chk("a_rs2", a_rs2, q[0].instr[24:20]);
            chk("b_rs1", b_rs1, q[0].instr[19:15]);
            chk("b_rs2", b_rs2, q[0].instr[24:20]);
            chk("a_pc", a_pc, q[0].pc[31:0]);    chk("b_pc", b_pc, q[0].pc);
        end
    endtask

    always @(negedge clk) begin
        if (run_checks && rst === 1'b1) check_all();
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        logic [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        w   = $urandom;
        sel = int'($urandom_range(0, 11));
        if (sel < 9) w[6:0] = ops[sel];
        else if (sel == 9) w[6:0] = 7'h33;
        else if (sel == 10) w[6:0] = 7'h13;
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        if (w[6:0] == 7'h13 && $urandom_range(0, 2) != 0) begin
            w[31:26] = 6'd0;
            w[30]    = 1'($urandom_range(0, 1));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    exp_t p;

    initial begin
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        // Pin the reference model with hand-decoded words.
        p = model_dec(32'h002081B3, 0, 0);
        chk("model_add_alu", p.alu, 0); chk("model_add_fmt", p.fmt, 0);
        p = model_dec(32'h402081B3, 0, 0);
        chk("model_sub_alu", p.alu, 1);
        p = model_dec(32'hFFF00093, 0, 0);
        chk("model_addi_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_addi_fmt", p.fmt, 1);
        p = model_dec(32'h0000007F, 0, 0);
        chk("model_bad_op", p.ill, 1);
        p = model_dec(32'h02208033, 0, 0);
        chk("model_mul_nomext", p.ill, 1);
        p = model_dec(32'h02208033, 1, 1);
        chk("model_mul_alu", p.alu, 16);
        p = model_dec(32'hFE000EE3, 0, 0);   // beq x0,x0,-4
        chk("model_beq_imm", p.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        p = model_dec(32'h0020B023, 0, 0);   // sd on RV32
        chk("model_sd_rv32", p.ill, 1);
        p = model_dec(32'h0020B023, 1, 1);
        chk("model_sd_rv64", p.msz, 3);
        p = model_dec(32'h0200D093, 0, 0);   // srli with instr[25] set on RV32
        chk("model_srli_rv32", p.ill, 1);
        p = model_dec(32'h4200D093, 1, 1);   // srai shamt 32 on RV64
        chk("model_srai_rv64", p.imm, 64'd32);
        p = model_dec(32'h800000B7, 1, 1);   // lui x1,0x80000
        chk("model_lui_imm", p.imm, 64'hFFFF_FFFF_8000_0000);

        // Reset state.
        #1;
        chk("rst_a_valid", a_out_valid, 0); chk("rst_a_ready", a_in_ready, 0);
        chk("rst_a_cnt", a_cnt, 0);         chk("rst_a_alu", a_alu, 0);
        chk("rst_b_valid", b_out_valid, 0); chk("rst_b_imm", b_imm, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_checks = 1;
        tick();
        chk("rst_ready_rise", a_in_ready, 1);

        // Single R-type into an empty buffer.
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h100;
        tick();
        in_valid = 1'b0;
        chk("add_valid", a_out_valid, 1); chk("add_alu", a_alu, 0);
        chk("add_fmt", a_fmt, 0);         chk("add_rd", a_rd, 3);
        chk("add_rs1", a_rs1, 1);         chk("add_rs2", a_rs2, 2);
        chk("add_pc", a_pc, 32'h100);
        tick();

        // Back-to-back SUB then ADDI -1.
        in_valid = 1'b1; in_instr = 32'h402081B3;
        tick();
        chk("b2b_sub_alu", a_alu, 1);
        in_instr = 32'hFFF00093;
        tick();
        in_valid = 1'b0;
        chk("b2b_addi_valid", a_out_valid, 1); chk("b2b_addi_alu", a_alu, 0);
        chk("b2b_addi_fmt", a_fmt, 1);         chk("b2b_addi_imm", a_imm, 32'hFFFF_FFFF);
        chk("b2b_addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("b2b_drained", a_out_valid, 0);

        // Backpressure: third offer held until a slot frees.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
        tick();
        in_instr = 32'h00200113;
        tick();
        chk("full_ready0", a_in_ready, 0);
        in_instr = 32'h00300193;
        tick();
        chk("full_hold_ready", a_in_ready, 0); chk("full_head1", a_rd, 1);
        out_ready = 1'b1;
        tick();
        chk("pop_ready1", a_in_ready, 1); chk("pop_head2", a_rd, 2);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("order_head3", a_rd, 3);
        tick();
        chk("order_empty", a_out_valid, 0);

        // Illegal words and the M extension.
        in_valid = 1'b1; in_instr = 32'h0000007F;
        tick();
        chk("ill_a_first", a_ill, 1); chk("ill_b_first", b_ill, 1);
        in_instr = 32'h02208033;
        tick();
        in_valid = 1'b0;
        chk("ill_a_mul", a_ill, 1); chk("ill_a_cnt", a_cnt, 2);
        chk("mext_b_alu", b_alu, 16); chk("mext_b_ill", b_ill, 0);
        chk("ill_b_cnt", b_cnt, 1);
        tick();

        // Flush with two entries buffered and an offer pending.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F;
        tick();
        in_instr = 32'h00000013;
        tick();
        chk("pre_flush_cnt", a_cnt, 3);
        flush = 1'b1; in_instr = 32'h0000007F;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", a_out_valid, 0); chk("flush2_cnt", a_cnt, 3);
        chk("flush2_ready", a_in_ready, 1);
        // Flush at occupancy one: the same-cycle illegal offer is dropped.
        in_valid = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_valid", a_out_valid, 0); chk("flush1_cnt", a_cnt, 4);

        // Asynchronous reset with one entry buffered.
        in_valid = 1'b1; in_instr = 32'h0000007F;
        tick();
        in_valid = 1'b0;
        chk("arst_pre_valid", a_out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", a_out_valid, 0); chk("arst_cnt", a_cnt, 0);
        chk("arst_ready", a_in_ready, 0);  chk("arst_b_cnt", b_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("arst_ready_rise", a_in_ready, 1); chk("arst_empty", a_out_valid, 0);

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("final_empty", a_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_decode_pipe.md
ALU_DECODE_PIPE -- requirements
Module: alu_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC and immediate; legal values 32 and 64.
REQ-002 Parameter EN_MEXT, default 0, 1 enables decode of the RV M-extension (funct7=0000001, opcode 0110011).
REQ-003 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  instruction offered.
REQ-007 in_ready  out  1  stage can accept.
REQ-008 in_instr  in  32  instruction word.
REQ-009 in_pc  in  XLEN  instruction address.
REQ-010 flush  in  1  discard all buffered entries.
REQ-011 out_valid  out  1  decoded entry available.
REQ-012 out_ready  in  1  consumer accepts.
REQ-013 out_alu_op  out  5  ALU operation code.
REQ-014 out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, LOAD=6, NONE=7.
REQ-015 out_imm  out  XLEN  sign-extended immediate (0 for R).
REQ-016 out_br_type  out  3  funct3 for B-type, else 0.
REQ-017 out_mem_size  out  2  0=byte, 1=half, 2=word, 3=dword (XLEN=64 only), loads/stores only.
REQ-018 out_mem_unsigned  out  1  LBU/LHU/LWU.
REQ-019 out_rd, out_rs1, out_rs2  out  5 each  register indices from instr[11:7], [19:15], [24:20].
REQ-020 out_pc  out  XLEN  PC of the entry.
REQ-021 out_illegal  out  1  entry is an undecodable instruction.
REQ-022 illegal_cnt  out  CNT_W  saturating count of illegal entries accepted.

Function
REQ-023 ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10 (LUI), MUL..REMU 16..23 in funct3 order when EN_MEXT=1.
REQ-024 Loads, stores, JAL, JALR, AUIPC use ADD; branches use SUB (BEQ/BNE/BLT/BGE) or SLTU (BLTU/BGEU).
REQ-025 Decode uses opcode, funct3 and funct7 only; immediate bits never select the operation.
REQ-026 SLLI/SRLI/SRAI take shamt from instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64); nonzero upper funct bits other than bit30 on SRAI mark illegal.
REQ-027 Illegal = unknown opcode, unknown funct3/funct7 combination, M-ext when EN_MEXT=0, or dword access when XLEN=32; illegal entries carry alu_op 0, fmt NONE, imm 0.
REQ-028 Decoded entries are held in a 2-entry FIFO; decode is combinational on in_instr, storage is registered.
REQ-029 Accept occurs when in_valid && in_ready; in_ready is registered and equals (occupancy < 2).
REQ-030 Latency: an entry accepted into an empty FIFO is visible at out_valid the next cycle.
REQ-031 Throughput: one accept and one release per cycle sustained with out_ready=1.
REQ-032 Simultaneous accept and release at occupancy 2 is not allowed (in_ready=0); at occupancy 1 occupancy stays 1.
REQ-033 Outputs present the head entry; they are stable while out_valid && !out_ready.
REQ-034 flush empties the FIFO next edge, suppresses any same-cycle accept, and leaves illegal_cnt unchanged.
REQ-035 illegal_cnt increments on accept of an illegal instruction (not flushed), saturating at all-ones.
REQ-036 Read/write pointers are 1 bit and wrap 1->0.

Reset
REQ-037 On rst low, asynchronously: occupancy 0, pointers 0, out_valid 0, in_ready 0, illegal_cnt 0, all data outputs 0.
REQ-038 in_ready rises on the first clock edge after rst deasserts; reset mid-transfer drops buffered entries without signalling.

Verification
REQ-039 Accept 0x002081B3 into empty FIFO, out_ready=1 -> next cycle out_valid=1, alu_op 0, fmt 0, rd 3, rs1 1, rs2 2.
REQ-040 Accept 0x402081B3 then 0xFFF00093 back-to-back -> alu_op 1 then alu_op 0, fmt 1, imm all-ones, one per cycle.
REQ-041 out_ready=0, offer 3 instructions -> first two accepted, in_ready=0, third held; release head -> in_ready=1 next cycle, order preserved.
REQ-042 Accept 0x0000007F and 0x02208033 with EN_MEXT=0 -> both out_illegal=1, illegal_cnt=2; with EN_MEXT=1 second gives alu_op 16.
REQ-043 Two entries buffered, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy 0, illegal_cnt unchanged.
REQ-044 Pull rst low with one entry buffered -> out_valid=0 immediately, illegal_cnt=0, in_ready=1 one edge after release.
